// File: rtl/instr_fetch_mem_if.sv
// Fetch and program-load bus between the PC/fetch stage (master) and the
// instruction memory (slave). Widths must match the memory's DATA_W/ADDR_W.
interface instr_fetch_mem_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);
  // fetch request / response
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_ready;
  logic              instr_valid;
  logic [DATA_W-1:0] instr;
  logic [DATA_W-1:0] instr_next;
  logic              fetch_fault;

  // streaming program load
  logic              load_start;
  logic              load_valid;
  logic              load_last;
  logic [DATA_W-1:0] load_data;
  logic              load_ready;
  logic              load_done;
  logic              load_trunc;
  logic [ADDR_W:0]   prog_len;

  modport master (
    output fetch_req, fetch_addr,
    output load_start, load_valid, load_last, load_data,
    input  fetch_ready, instr_valid, instr, instr_next, fetch_fault,
    input  load_ready, load_done, load_trunc, prog_len
  );

  modport slave (
    input  fetch_req, fetch_addr,
    input  load_start, load_valid, load_last, load_data,
    output fetch_ready, instr_valid, instr, instr_next, fetch_fault,
    output load_ready, load_done, load_trunc, prog_len
  );
endinterface

// File: rtl/instr_fetch_mem.sv
// Loadable instruction memory with a one-cycle registered fetch port that
// returns the word at the PC and the following word (lookahead). Words at or
// beyond the loaded program length read as NOP_WORD and flag a fault.
// Fetches are only accepted in S_RUN and writes only happen in S_LOAD, so the
// array never sees a read and a write in the same cycle.
module instr_fetch_mem #(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 8,
  parameter int                DEPTH    = 32,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(16'h0000)
) (
  input logic              clk,
  input logic              rst_n,
  instr_fetch_mem_if.slave bus
);

  localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    S_RUN  = 1'b0,
    S_LOAD = 1'b1
  } state_t;

  // Select the stored word only when it lies inside the loaded program.
  function automatic logic [DATA_W-1:0] sel_word(input logic hit,
                                                 input logic [DATA_W-1:0] word);
    return hit ? word : NOP_WORD;
  endfunction

  // Program array; intentionally not reset, prog_len masks stale contents.
  logic [DATA_W-1:0] r_mem [0:DEPTH-1];

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_fetch_ready;
  logic              w_load_ready;

  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W:0]   r_prog_len;
  logic              r_load_done;
  logic              r_load_trunc;

  logic              r_vld_p1;
  logic [DATA_W-1:0] r_instr_p1;
  logic [DATA_W-1:0] r_instr_next_p1;
  logic              r_fault_p1;

  logic              w_fetch_acc;
  logic              w_run_start;
  logic              w_load_restart;
  logic              w_load_wr;
  logic              w_load_exit;
  logic [ADDR_W:0]   w_ptr_inc;
  logic [ADDR_W:0]   w_addr_ext;
  logic [ADDR_W:0]   w_addr_inc;
  logic              w_hit0;
  logic              w_hit1;
  logic [DATA_W-1:0] w_word0;
  logic [DATA_W-1:0] w_word1;

  // Control decode. A load_start inside S_LOAD wins over load_valid, so a
  // restart cycle never writes.
  assign w_fetch_acc    = bus.fetch_req && w_fetch_ready;
  assign w_run_start    = (r_state == S_RUN) && bus.load_start;
  assign w_load_restart = (r_state == S_LOAD) && bus.load_start;
  assign w_load_wr      = (r_state == S_LOAD) && bus.load_valid && !bus.load_start;
  assign w_load_exit    = w_load_wr && (bus.load_last || (r_wr_ptr == LAST_PTR));
  assign w_ptr_inc      = {1'b0, r_wr_ptr} + (ADDR_W+1)'(1);

  // Read path. The lookahead address is formed one bit wider so the top
  // address does not wrap around to word 0. Both hits imply an in-array
  // index because prog_len never exceeds DEPTH.
  assign w_addr_ext = {1'b0, bus.fetch_addr};
  assign w_addr_inc = w_addr_ext + (ADDR_W+1)'(1);
  assign w_hit0     = (w_addr_ext < r_prog_len);
  assign w_hit1     = (w_addr_inc < r_prog_len);
  assign w_word0    = r_mem[bus.fetch_addr[IDX_W-1:0]];
  assign w_word1    = r_mem[w_addr_inc[IDX_W-1:0]];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: enter load on load_start, leave on last word or full array.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RUN:   if (bus.load_start) w_state_nxt = S_LOAD;
      S_LOAD:  if (w_load_exit)    w_state_nxt = S_RUN;
      default: w_state_nxt = S_RUN;
    endcase
  end

  // State outputs: the two ports are mutually exclusive.
  always_comb begin
    w_fetch_ready = 1'b0;
    w_load_ready  = 1'b0;
    case (r_state)
      S_RUN:   w_fetch_ready = 1'b1;
      S_LOAD:  w_load_ready  = 1'b1;
      default: w_fetch_ready = 1'b1;
    endcase
  end

  // Load bookkeeping: write pointer, program length and completion pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr     <= '0;
      r_prog_len   <= '0;
      r_load_done  <= 1'b0;
      r_load_trunc <= 1'b0;
    end else begin
      if (w_run_start || w_load_restart) begin
        r_wr_ptr   <= '0;
        r_prog_len <= '0;
      end else if (w_load_wr) begin
        r_wr_ptr   <= w_ptr_inc[ADDR_W-1:0];
        r_prog_len <= w_ptr_inc;
      end
      r_load_done  <= w_load_exit;
      r_load_trunc <= w_load_exit && !bus.load_last;
    end
  end

  // Array write port, one word per accepted load beat.
  always_ff @(posedge clk) begin
    if (w_load_wr) begin
      r_mem[r_wr_ptr[IDX_W-1:0]] <= bus.load_data;
    end
  end

  // ---- stage p0 -> p1: address in, registered response out ----
  // Response registers; data holds between fetches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1        <= 1'b0;
      r_instr_p1      <= NOP_WORD;
      r_instr_next_p1 <= NOP_WORD;
      r_fault_p1      <= 1'b0;
    end else begin
      r_vld_p1 <= w_fetch_acc;
      if (w_fetch_acc) begin
        r_instr_p1      <= sel_word(w_hit0, w_word0);
        r_instr_next_p1 <= sel_word(w_hit1, w_word1);
        r_fault_p1      <= !w_hit0;
      end
    end
  end

  assign bus.fetch_ready = w_fetch_ready;
  assign bus.instr_valid = r_vld_p1;
  assign bus.instr       = r_instr_p1;
  assign bus.instr_next  = r_instr_next_p1;
  assign bus.fetch_fault = r_fault_p1;
  assign bus.load_ready  = w_load_ready;
  assign bus.load_done   = r_load_done;
  assign bus.load_trunc  = r_load_trunc;
  assign bus.prog_len    = r_prog_len;

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Self-checking bench for instr_fetch_mem: a reference model of the program
// array predicts each fetch response into a queue; a negedge monitor pops
// and compares whenever the memory presents instr_valid.
module tb_instr_fetch_mem;

  localparam int                DATA_W = 16;
  localparam int                ADDR_W = 8;
  localparam int                DEPTH  = 32;
  localparam logic [DATA_W-1:0] NOP    = 16'h0000;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  instr_fetch_mem_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  instr_fetch_mem #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .DEPTH   (DEPTH),
    .NOP_WORD(NOP)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] instr;
    logic [15:0] nxt;
    logic        fault;
  } exp_t;

  exp_t        exp_q[$];
  int          n_chk  = 0;
  int          n_pass = 0;
  logic [15:0] m_mem [0:DEPTH-1];
  int          m_wp   = 0;
  int          m_len  = 0;
  bit          m_load = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
  endtask

  function automatic exp_t model_fetch(input int a);
    exp_t e;
    e.addr  = a[7:0];
    e.instr = (a < m_len)     ? m_mem[a]     : NOP;
    e.nxt   = (a + 1 < m_len) ? m_mem[a + 1] : NOP;
    e.fault = (a >= m_len);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_fetch_ready"}, 32'(bus.fetch_ready), 32'd1);
    chk({tag, "_instr_valid"}, 32'(bus.instr_valid), 32'd0);
    chk({tag, "_instr"},       32'(bus.instr),       32'(NOP));
    chk({tag, "_instr_next"},  32'(bus.instr_next),  32'(NOP));
    chk({tag, "_fault"},       32'(bus.fetch_fault), 32'd0);
    chk({tag, "_load_ready"},  32'(bus.load_ready),  32'd0);
    chk({tag, "_load_done"},   32'(bus.load_done),   32'd0);
    chk({tag, "_load_trunc"},  32'(bus.load_trunc),  32'd0);
    chk({tag, "_prog_len"},    32'(bus.prog_len),    32'd0);
  endtask

  task automatic do_fetch(input int a, input bit with_start = 1'b0);
    chk("fetch_ready", 32'(bus.fetch_ready), 32'd1);
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = a[7:0];
    bus.load_start = with_start;
    exp_q.push_back(model_fetch(a));
    tick();
    bus.fetch_req  = 1'b0;
    bus.load_start = 1'b0;
    if (with_start) begin
      m_load = 1'b1;
      m_wp   = 0;
      m_len  = 0;
      chk("load_ready_after_start", 32'(bus.load_ready), 32'd1);
    end
  endtask

  task automatic load_begin();
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    m_load = 1'b1;
    m_wp   = 0;
    m_len  = 0;
    chk("load_ready",     32'(bus.load_ready),  32'd1);
    chk("fetch_blocked",  32'(bus.fetch_ready), 32'd0);
    chk("prog_len_clear", 32'(bus.prog_len),    32'd0);
  endtask

  task automatic load_word(input logic [15:0] d, input bit last);
    bit ex = 1'b0;
    bit tr = 1'b0;
    if (m_load) begin
      m_mem[m_wp] = d;
      ex     = last || (m_wp == DEPTH - 1);
      tr     = ex && !last;
      m_wp   = m_wp + 1;
      m_len  = m_wp;
      m_load = !ex;
    end
    bus.load_valid = 1'b1;
    bus.load_data  = d;
    bus.load_last  = last;
    tick();
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
    chk("load_done",  32'(bus.load_done),  32'(ex));
    chk("load_trunc", 32'(bus.load_trunc), 32'(tr));
    chk("prog_len",   32'(bus.prog_len),   32'(m_len));
    if (ex) chk("fetch_ready_at_done", 32'(bus.fetch_ready), 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
  endtask

  // Response monitor: every instr_valid must match the oldest prediction.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n === 1'b1 && bus.instr_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("instr@%0d", e.addr),      32'(bus.instr),       32'(e.instr));
        chk($sformatf("instr_next@%0d", e.addr), 32'(bus.instr_next),  32'(e.nxt));
        chk($sformatf("fault@%0d", e.addr),      32'(bus.fetch_fault), 32'(e.fault));
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [15:0] prog [0:5];
    prog[0] = 16'h1012; prog[1] = 16'h1013; prog[2] = 16'h10B4;
    prog[3] = 16'h8232; prog[4] = 16'h6246; prog[5] = 16'h5003;

    bus.fetch_req  = 1'b0;
    bus.fetch_addr = '0;
    bus.load_start = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
    bus.load_data  = '0;
    rst_n          = 1'b0;

    // reset state
    #12;
    check_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // empty program: NOP with fault
    do_fetch(0);
    drain();

    // six-word program
    load_begin();
    for (int i = 0; i < 6; i++) load_word(prog[i], i == 5);
    tick();
    chk("load_done_one_cycle", 32'(bus.load_done), 32'd0);
    chk("prog_len_6",          32'(bus.prog_len),  32'd6);
    do_fetch(3);
    do_fetch(5);
    do_fetch(0);
    do_fetch(1);
    do_fetch(2);
    do_fetch(200);
    do_fetch(255);
    drain();

    // overlong stream truncated at DEPTH words
    load_begin();
    for (int i = 1; i <= 40; i++) load_word(16'hA000 + 16'(i), 1'b0);
    chk("prog_len_full", 32'(bus.prog_len), 32'(DEPTH));
    do_fetch(31);
    do_fetch(32);
    do_fetch(0);
    drain();

    // fetch in the load_start cycle uses the old program, then restart mid-load
    do_fetch(3, 1'b1);
    for (int i = 0; i < 3; i++) load_word(16'h2001 + 16'(i), 1'b0);
    bus.load_start = 1'b1;
    bus.load_valid = 1'b1;
    bus.load_data  = 16'hDEAD;
    tick();
    bus.load_start = 1'b0;
    bus.load_valid = 1'b0;
    m_wp  = 0;
    m_len = 0;
    chk("restart_prog_len",   32'(bus.prog_len),   32'd0);
    chk("restart_load_ready", 32'(bus.load_ready), 32'd1);
    load_word(16'h3001, 1'b0);
    load_word(16'h3002, 1'b1);
    do_fetch(0);
    do_fetch(1);
    do_fetch(2);
    drain();

    // asynchronous reset in the middle of a load
    load_begin();
    for (int i = 0; i < 4; i++) load_word(16'h4001 + 16'(i), 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midload_rst");
    m_load = 1'b0;
    m_wp   = 0;
    m_len  = 0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    do_fetch(0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/instr_fetch_mem.md
# instr_fetch_mem

Parametrised, loadable instruction memory with a registered fetch port and one-word lookahead. It sits between the PC/fetch stage and the decoder. A streaming program-load port replaces the fixed initial image. Addresses outside the loaded program, or outside the array, return a NOP word and raise a fault flag.

## Interface
Parameters:
- DATA_W, 16, instruction word width
- ADDR_W, 8, fetch/load address width
- DEPTH, 32, physical words; must be ≤ 2**ADDR_W
- NOP_WORD, 16'h0000, value returned for unloaded or out-of-range words (DATA_W bits)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- fetch_req  in  1  fetch request
- fetch_addr  in  ADDR_W  word address (PC)
- fetch_ready  out  1  fetch accepted when fetch_req && fetch_ready
- instr_valid  out  1  response strobe, one cycle per accepted fetch
- instr  out  DATA_W  word at the fetched address
- instr_next  out  DATA_W  word at fetched address + 1 (lookahead)
- fetch_fault  out  1  fetched address ≥ prog_len; qualified by instr_valid
- load_start  in  1  pulse: begin a new program load
- load_valid  in  1  load_data valid
- load_last  in  1  marks the final word; qualified by load_valid
- load_data  in  DATA_W  program word
- load_ready  out  1  load port accepting words
- load_done  out  1  one-cycle pulse, load finished
- load_trunc  out  1  one-cycle pulse with load_done: array filled before load_last
- prog_len  out  ADDR_W+1  number of valid loaded words

## Operation
- FSM has two states, S_RUN and S_LOAD. Reset state is S_RUN.
- fetch_ready = (state == S_RUN). load_ready = (state == S_LOAD).
- S_RUN to S_LOAD: load_start = 1. wr_ptr ← 0 and prog_len ← 0 on the same edge.
- S_LOAD, load_valid = 1:
  - mem[wr_ptr] ← load_data
  - wr_ptr ← wr_ptr + 1
  - prog_len ← wr_ptr + 1
- S_LOAD to S_RUN:
  - Taken when load_valid && (load_last || wr_ptr == DEPTH-1).
  - load_done pulses the following cycle.
  - load_trunc pulses with it when the exit was caused by wr_ptr == DEPTH-1 without load_last.
- load_start in S_LOAD restarts the load: wr_ptr ← 0, prog_len ← 0, state stays S_LOAD. Any load_valid in that same cycle is ignored.
- load_valid or load_last in S_RUN: ignored, with no write.
- Fetch read rules, for an accepted fetch at address a:
  - instr = (a < prog_len) ? mem[a] : NOP_WORD
  - instr_next = (a+1 < prog_len) ? mem[a+1] : NOP_WORD
  - Compute a+1 in ADDR_W+1 bits, so a = 2**ADDR_W−1 yields NOP_WORD with no wrap to 0.
  - fetch_fault = (a ≥ prog_len)
- prog_len ≤ DEPTH always, so out-of-array addresses are always NOP and faulted.
- The array is not cleared by reset. prog_len = 0 after reset, so every fetch returns NOP_WORD with fault = 1 until a load completes.
- Fetch and load_start in the same S_RUN cycle: the fetch is served from the current program, then the load begins.

## Timing
- Reset values:
  - fetch_ready = 1, instr_valid = 0
  - instr = instr_next = NOP_WORD, fetch_fault = 0
  - load_ready = 0, load_done = 0, load_trunc = 0
  - prog_len = 0, wr_ptr = 0, state = S_RUN
- Fetch latency is 1 cycle: an accept at edge N gives instr_valid, instr, instr_next and fetch_fault registered after edge N.
  - Throughput is one fetch per cycle.
  - instr and instr_next hold their value when instr_valid = 0.
- Load throughput is one word per cycle. load_ready rises the cycle after load_start.
- load_done is high exactly one cycle, the cycle after the last write. fetch_ready is high in that same cycle.
- A write to mem[k] is visible to any fetch accepted after the write edge. No read and write ever occur in the same cycle, because fetch is blocked in S_LOAD.
- Reset asserted mid-load or mid-fetch:
  - All outputs and state take their reset values immediately.
  - Partial array contents remain, but prog_len = 0 masks them.

## Test plan
- Reset release, fetch addr 0 → next cycle instr_valid = 1, instr = 0x0000, instr_next = 0x0000, fetch_fault = 1.
- Load 6 words (0x1012, 0x1013, 0x10B4, 0x8232, 0x6246, 0x5003) with load_last on the 6th.
  - Expect load_done one cycle later and prog_len = 6.
  - Fetch 3 → instr = 0x8232, instr_next = 0x6246, fault = 0.
  - Fetch 5 → instr = 0x5003, instr_next = NOP, fault = 0.
- Back-to-back fetches 0,1,2 on consecutive cycles → three consecutive instr_valid cycles with the matching words. Fetch 200 → NOP with fault = 1.
- DEPTH = 32: stream 40 words without load_last.
  - Exit after word 32 with load_done = load_trunc = 1 and prog_len = 32.
  - Words 33–40 are ignored; fetch 31 returns word 32.
- load_start after 3 words of a load, then load 2 words with load_last → prog_len = 2, and fetch 2 faults.
- rst_n low mid-load at word 4 → all outputs at reset values, and fetch 0 returns NOP with fault = 1.
